mem_1r1w_masked_fwd_32x136: RTL and testbench

// Front-end stage placed directly upstream of the 32x136 byte-masked 1R1W SRAM wrapper (8-bit mask granule).
// It drives the wrapper's R0/W0 ports and guarantees the macro never sees a same-address read/write collision.
// A colliding write is parked for one or more cycles in a hold buffer.

---
 rtl/mem_1r1w_masked_fwd_32x136.sv | 132 +++++++++++++
 tb/tb_mem_1r1w_masked_fwd_32x136.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_1r1w_masked_fwd_32x136.sv
// Front end for a 32x136 byte-masked 1R1W SRAM wrapper.
// Keeps same-address read/write pairs away from the macro by parking the
// colliding write in a one-entry hold buffer. The parked bytes are forwarded
// into the read response, so clients see write-before-read semantics.
module mem_1r1w_masked_fwd_32x136 #(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 136,
  parameter int MASK_GRAN = 8,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int MASK_W    = WIDTH / MASK_GRAN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_resp_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  output logic [ADDR_W-1:0] mem_R0_addr,
  output logic              mem_R0_en,
  input  logic [WIDTH-1:0]  mem_R0_data,
  output logic [ADDR_W-1:0] mem_W0_addr,
  output logic              mem_W0_en,
  output logic [WIDTH-1:0]  mem_W0_data,
  output logic [MASK_W-1:0] mem_W0_mask
);

  // Hold buffer: the single uncommitted write, if any
  logic              hb_valid;
  logic [ADDR_W-1:0] hb_addr;
  logic [WIDTH-1:0]  hb_data;
  logic [MASK_W-1:0] hb_mask;

  // Forwarding state and response flag for the read issued last cycle
  logic              fw_hit_p1;
  logic [WIDTH-1:0]  fw_data_p1;
  logic [MASK_W-1:0] fw_mask_p1;
  logic              vld_p1;
  logic [WIDTH-1:0]  rd_hold_p1;
  logic [WIDTH-1:0]  rd_merged_p1;

  // Write candidate for this cycle
  logic              wr_take;
  logic              cand_valid;
  logic [ADDR_W-1:0] cand_addr;
  logic [WIDTH-1:0]  cand_data;
  logic [MASK_W-1:0] cand_mask;
  logic              collide;

  // Overlay the granules selected by sel from fwd onto base
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]  base,
                                                   input logic [WIDTH-1:0]  fwd,
                                                   input logic [MASK_W-1:0] sel);
    logic [WIDTH-1:0] r;
    r = base;
    for (int i = 0; i < MASK_W; i++) begin
      if (sel[i]) r[i*MASK_GRAN +: MASK_GRAN] = fwd[i*MASK_GRAN +: MASK_GRAN];
    end
    return r;
  endfunction

  // Ready depends only on the hold buffer, never on the read request
  assign wr_ready = !hb_valid;

  // Pick the write candidate (parked write has priority) and detect a collision
  always_comb begin
    wr_take    = wr_valid && !hb_valid;
    cand_valid = hb_valid || wr_take;
    cand_addr  = hb_valid ? hb_addr : wr_addr;
    cand_data  = hb_valid ? hb_data : wr_data;
    cand_mask  = hb_valid ? hb_mask : wr_mask;
    collide    = rd_valid && cand_valid && (cand_addr == rd_addr);
  end

  // Drive the macro ports; both are quiet while reset is held
  always_comb begin
    mem_R0_en   = rd_valid && !reset;
    mem_R0_addr = rd_addr;
    mem_W0_en   = cand_valid && !collide && !reset;
    mem_W0_addr = cand_addr;
    mem_W0_data = cand_data;
    mem_W0_mask = mem_W0_en ? cand_mask : '0;
  end

  // Hold-buffer valid: set on a collision, cleared once the write reaches the macro
  always_ff @(posedge clock) begin
    if (reset) hb_valid <= 1'b0;
    else       hb_valid <= collide;
  end

  // Hold-buffer payload and forwarding payload capture the colliding candidate
  always_ff @(posedge clock) begin
    if (collide) begin
      hb_addr    <= cand_addr;
      hb_data    <= cand_data;
      hb_mask    <= cand_mask;
      fw_data_p1 <= cand_data;
      fw_mask_p1 <= cand_mask;
    end
  end

  // ---- stage boundary: request cycle -> response cycle ----
  // Response control: forward flag and response valid
  always_ff @(posedge clock) begin
    if (reset) begin
      fw_hit_p1 <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      fw_hit_p1 <= collide;
      vld_p1    <= rd_valid;
    end
  end

  // Merge uncommitted bytes over the macro read data
  always_comb begin
    rd_merged_p1 = fw_hit_p1 ? merge_bytes(mem_R0_data, fw_data_p1, fw_mask_p1) : mem_R0_data;
  end

  // Keep the last response so rd_data is stable between responses
  always_ff @(posedge clock) begin
    if (reset)       rd_hold_p1 <= '0;
    else if (vld_p1) rd_hold_p1 <= rd_merged_p1;
  end

  assign rd_resp_valid = vld_p1;
  assign rd_data       = vld_p1 ? rd_merged_p1 : rd_hold_p1;

endmodule

// File: tb/tb_mem_1r1w_masked_fwd_32x136.sv
// Bench for mem_1r1w_masked_fwd_32x136: a behavioural SRAM wrapper model on the
// macro side and a client-view reference (committed words plus one pending write).
module tb_mem_1r1w_masked_fwd_32x136;

  logic         clock = 1'b0;
  logic         reset;
  logic         rd_valid;
  logic [4:0]   rd_addr;
  logic         rd_resp_valid;
  logic [135:0] rd_data;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [135:0] wr_data;
  logic [16:0]  wr_mask;
  logic [4:0]   mem_R0_addr;
  logic         mem_R0_en;
  logic [135:0] mem_R0_data = '0;
  logic [4:0]   mem_W0_addr;
  logic         mem_W0_en;
  logic [135:0] mem_W0_data;
  logic [16:0]  mem_W0_mask;

  always #5 clock = ~clock;

  mem_1r1w_masked_fwd_32x136 dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .mem_R0_addr(mem_R0_addr), .mem_R0_en(mem_R0_en), .mem_R0_data(mem_R0_data),
    .mem_W0_addr(mem_W0_addr), .mem_W0_en(mem_W0_en),
    .mem_W0_data(mem_W0_data), .mem_W0_mask(mem_W0_mask)
  );

  function automatic logic [135:0] apply_mask(input logic [135:0] old, input logic [135:0] d,
                                              input logic [16:0] m);
    logic [135:0] r;
    r = old;
    for (int i = 0; i < 17; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [135:0] rand136();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[135:0];
  endfunction

  // Behavioural SRAM wrapper: registered read, byte-masked write
  logic [135:0] sram [32] = '{default: '0};
  always @(posedge clock) begin
    if (mem_R0_en) mem_R0_data <= sram[mem_R0_addr];
    if (mem_W0_en) sram[mem_W0_addr] <= apply_mask(sram[mem_W0_addr], mem_W0_data, mem_W0_mask);
  end

  // Client-view reference
  logic [135:0] ref_mem [32];
  bit           pend_v;
  logic [4:0]   pend_a;
  logic [135:0] pend_d;
  logic [16:0]  pend_m;
  logic [135:0] last_rd;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed and expected values of the most recent step
  logic         obs_ready, obs_wen, obs_ren, obs_coll, obs_rvalid;
  logic [4:0]   obs_waddr;
  logic [16:0]  obs_wmask;
  logic [135:0] obs_wdata, obs_rdata;
  logic         exp_ready, exp_wen, exp_ren, exp_rvalid;
  logic [4:0]   exp_waddr;
  logic [16:0]  exp_wmask;
  logic [135:0] exp_wdata, exp_rdata;

  // Drive one cycle, sample the combinational outputs before the edge and the
  // registered outputs after it, and advance the reference
  task automatic step(input bit rst, input bit rv, input logic [4:0] ra, input bit wv,
                      input logic [4:0] wa, input logic [135:0] wd, input logic [16:0] wm);
    bit acc, cv, coll;
    logic [4:0] ca;
    logic [135:0] cd, view;
    logic [16:0] cm;
    @(negedge clock);
    reset = rst; rd_valid = rv; rd_addr = ra;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_mask = wm;
    #1;
    obs_ready = wr_ready; obs_wen = mem_W0_en; obs_waddr = mem_W0_addr;
    obs_wdata = mem_W0_data; obs_wmask = mem_W0_mask; obs_ren = mem_R0_en;
    obs_coll  = mem_R0_en && mem_W0_en && (mem_R0_addr == mem_W0_addr);
    exp_ready = !pend_v;
    acc  = wv && !pend_v;
    cv   = pend_v || acc;
    ca   = pend_v ? pend_a : wa;
    cd   = pend_v ? pend_d : wd;
    cm   = pend_v ? pend_m : wm;
    coll = rv && cv && (ca == ra);
    exp_wen   = !rst && cv && !coll;
    exp_waddr = ca;
    exp_wdata = cd;
    exp_wmask = exp_wen ? cm : 17'h0;
    exp_ren   = rv && !rst;
    view = ref_mem[ra];
    if (pend_v && pend_a == ra) view = apply_mask(view, pend_d, pend_m);
    if (acc && wa == ra)        view = apply_mask(view, wd, wm);
    @(posedge clock);
    if (rst) begin
      pend_v = 1'b0; exp_rvalid = 1'b0; last_rd = '0;
    end else begin
      if (cv && !coll) begin
        ref_mem[ca] = apply_mask(ref_mem[ca], cd, cm);
        pend_v = 1'b0;
      end else if (cv) begin
        pend_v = 1'b1; pend_a = ca; pend_d = cd; pend_m = cm;
      end
      exp_rvalid = rv;
      if (rv) last_rd = view;
    end
    exp_rdata = last_rd;
    #1;
    obs_rvalid = rd_resp_valid;
    obs_rdata  = rd_data;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 0, 5'd0, '0, '0);
  endtask

  task automatic test_reset();
    step(1, 1, 5'd4, 1, 5'd4, rand136(), 17'h1FFFF);
    step(1, 1, 5'd4, 1, 5'd4, rand136(), 17'h1FFFF);
    n_cmp++; if (obs_wen !== 1'b0) begin n_bad++; $display("FAIL rst_w0en_in_reset got %b want 0", obs_wen); end
    n_cmp++; if (obs_ren !== 1'b0) begin n_bad++; $display("FAIL rst_r0en_in_reset got %b want 0", obs_ren); end
    n_cmp++; if (obs_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %b want 0", obs_rvalid); end
    n_cmp++; if (obs_rdata !== 136'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", obs_rdata); end
    idle();
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", obs_ready); end
    n_cmp++; if (obs_wen !== 1'b0) begin n_bad++; $display("FAIL rst_w0en got %b want 0", obs_wen); end
    n_cmp++; if (obs_wmask !== 17'h0) begin n_bad++; $display("FAIL rst_w0mask got %h want 0", obs_wmask); end
    n_cmp++; if (obs_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid_after got %b want 0", obs_rvalid); end
  endtask

  task automatic test_write_then_read();
    logic [135:0] d;
    d = rand136();
    step(0, 0, 5'd0, 1, 5'd3, d, 17'h1FFFF);
    n_cmp++; if (obs_wen !== 1'b1 || obs_waddr !== 5'd3) begin n_bad++; $display("FAIL wr_rd_commit got en=%b a=%0d want en=1 a=3", obs_wen, obs_waddr); end
    n_cmp++; if (obs_wdata !== d || obs_wmask !== 17'h1FFFF) begin n_bad++; $display("FAIL wr_rd_wdata got %h/%h want %h/1ffff", obs_wdata, obs_wmask, d); end
    step(0, 1, 5'd3, 0, 5'd0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL wr_rd_no_hb got ready=%b want 1", obs_ready); end
    n_cmp++; if (obs_rvalid !== 1'b1 || obs_rdata !== d) begin n_bad++; $display("FAIL wr_rd_data got v=%b %h want v=1 %h", obs_rvalid, obs_rdata, d); end
    idle();
    n_cmp++; if (obs_rvalid !== 1'b0 || obs_rdata !== d) begin n_bad++; $display("FAIL wr_rd_hold got v=%b %h want v=0 %h", obs_rvalid, obs_rdata, d); end
  endtask

  task automatic test_collision();
    step(0, 0, 5'd0, 1, 5'd5, '0, 17'h1FFFF);
    step(0, 1, 5'd5, 1, 5'd5, 136'hAB, 17'h00001);
    n_cmp++; if (obs_wen !== 1'b0) begin n_bad++; $display("FAIL coll_w0en got %b want 0", obs_wen); end
    n_cmp++; if (obs_ren !== 1'b1) begin n_bad++; $display("FAIL coll_r0en got %b want 1", obs_ren); end
    n_cmp++; if (obs_rvalid !== 1'b1 || obs_rdata !== 136'hAB) begin n_bad++; $display("FAIL coll_fwd got v=%b %h want v=1 ab", obs_rvalid, obs_rdata); end
    idle();
    n_cmp++; if (obs_ready !== 1'b0) begin n_bad++; $display("FAIL coll_ready got %b want 0", obs_ready); end
    n_cmp++; if (obs_wen !== 1'b1 || obs_waddr !== 5'd5 || obs_wmask !== 17'h1) begin n_bad++; $display("FAIL coll_commit got en=%b a=%0d m=%h want 1/5/1", obs_wen, obs_waddr, obs_wmask); end
    step(0, 1, 5'd5, 0, 5'd0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b1 || obs_rdata !== 136'hAB) begin n_bad++; $display("FAIL coll_readback got r=%b %h want r=1 ab", obs_ready, obs_rdata); end
  endtask

  task automatic test_starvation();
    logic [135:0] p, want;
    logic [16:0] m;
    p = rand136();
    m = 17'h0A5A5;
    want = apply_mask(ref_mem[7], p, m);
    step(0, 1, 5'd7, 1, 5'd7, p, m);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 5'd7, 1, 5'd7, rand136(), 17'h1FFFF);
      n_cmp++; if (obs_ready !== 1'b0 || obs_wen !== 1'b0) begin n_bad++; $display("FAIL starve_park[%0d] got r=%b en=%b want 0/0", k, obs_ready, obs_wen); end
      n_cmp++; if (obs_rdata !== want || obs_rdata !== exp_rdata) begin n_bad++; $display("FAIL starve_fwd[%0d] got %h want %h", k, obs_rdata, want); end
    end
    idle();
    n_cmp++; if (obs_wen !== 1'b1 || obs_waddr !== 5'd7 || obs_wdata !== p || obs_wmask !== m) begin n_bad++; $display("FAIL starve_commit got en=%b a=%0d m=%h want 1/7/%h", obs_wen, obs_waddr, obs_wmask, m); end
    step(0, 1, 5'd7, 0, 5'd0, '0, '0);
    n_cmp++; if (obs_ready !== 1'b1 || obs_rdata !== want) begin n_bad++; $display("FAIL starve_after got r=%b %h want r=1 %h", obs_ready, obs_rdata, want); end
  endtask

  task automatic test_disjoint();
    logic [135:0] old2;
    old2 = ref_mem[2];
    step(0, 1, 5'd2, 1, 5'd9, rand136(), 17'h1F0F0);
    n_cmp++; if (obs_wen !== 1'b1 || obs_ren !== 1'b1 || obs_waddr !== 5'd9) begin n_bad++; $display("FAIL disj_ports got w=%b r=%b a=%0d want 1/1/9", obs_wen, obs_ren, obs_waddr); end
    n_cmp++; if (obs_rdata !== old2) begin n_bad++; $display("FAIL disj_rdata got %h want %h", obs_rdata, old2); end
    idle();
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL disj_ready got %b want 1", obs_ready); end
  endtask

  task automatic test_reset_mid();
    logic [135:0] old;
    old = ref_mem[11];
    step(0, 1, 5'd11, 1, 5'd11, ~old, 17'h1FFFF);
    step(1, 1, 5'd11, 0, 5'd0, '0, '0);
    n_cmp++; if (obs_wen !== 1'b0) begin n_bad++; $display("FAIL rmid_w0en_in_reset got %b want 0", obs_wen); end
    n_cmp++; if (obs_rvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_rvalid got %b want 0", obs_rvalid); end
    idle();
    n_cmp++; if (obs_wen !== 1'b0 || obs_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_discard got en=%b r=%b want 0/1", obs_wen, obs_ready); end
    step(0, 1, 5'd11, 0, 5'd0, '0, '0);
    n_cmp++; if (obs_rdata !== old) begin n_bad++; $display("FAIL rmid_old got %h want %h", obs_rdata, old); end
  endtask

  task automatic test_back_to_back();
    logic [135:0] vals [32];
    for (int a = 0; a < 32; a++) begin
      vals[a] = rand136();
      step(0, 0, 5'd0, 1, 5'(a), vals[a], 17'h1FFFF);
      n_cmp++; if (obs_ready !== 1'b1 || obs_wen !== 1'b1 || obs_waddr !== 5'(a)) begin n_bad++; $display("FAIL b2b_wr[%0d] got r=%b en=%b a=%0d", a, obs_ready, obs_wen, obs_waddr); end
    end
    for (int a = 0; a < 32; a++) begin
      step(0, 1, 5'(a), 0, 5'd0, '0, '0);
      n_cmp++; if (obs_rvalid !== 1'b1 || obs_rdata !== vals[a]) begin n_bad++; $display("FAIL b2b_rd[%0d] got v=%b %h want %h", a, obs_rvalid, obs_rdata, vals[a]); end
    end
  endtask

  task automatic test_random();
    bit rst, rv, wv;
    logic [4:0] ra, wa;
    logic [16:0] m;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      rv  = ($urandom_range(0, 9) < 7);
      wv  = ($urandom_range(0, 9) < 6);
      ra  = 5'($urandom_range(0, 3));
      wa  = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin ra = 5'($urandom_range(0, 31)); wa = 5'($urandom_range(0, 31)); end
      m = ($urandom_range(0, 9) == 0) ? 17'h0 : 17'($urandom());
      step(rst, rv, ra, wv, wa, rand136(), m);
      n_cmp++; if (obs_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready[%0d] got %b want %b", k, obs_ready, exp_ready); end
      n_cmp++; if (obs_wen !== exp_wen || obs_wmask !== exp_wmask) begin n_bad++; $display("FAIL rnd_w0[%0d] got en=%b m=%h want en=%b m=%h", k, obs_wen, obs_wmask, exp_wen, exp_wmask); end
      if (exp_wen) begin
        n_cmp++; if (obs_waddr !== exp_waddr || obs_wdata !== exp_wdata) begin n_bad++; $display("FAIL rnd_w0data[%0d] got a=%0d %h want a=%0d %h", k, obs_waddr, obs_wdata, exp_waddr, exp_wdata); end
      end
      n_cmp++; if (obs_ren !== exp_ren) begin n_bad++; $display("FAIL rnd_r0en[%0d] got %b want %b", k, obs_ren, exp_ren); end
      n_cmp++; if (obs_coll !== 1'b0) begin n_bad++; $display("FAIL rnd_macro_collision[%0d] got %b want 0", k, obs_coll); end
      n_cmp++; if (obs_rvalid !== exp_rvalid || obs_rdata !== exp_rdata) begin n_bad++; $display("FAIL rnd_resp[%0d] got v=%b %h want v=%b %h", k, obs_rvalid, obs_rdata, exp_rvalid, exp_rdata); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rd_valid = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    pend_v = 1'b0; pend_a = '0; pend_d = '0; pend_m = '0; last_rd = '0;
    test_reset();
    test_write_then_read();
    test_collision();
    test_starvation();
    test_disjoint();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
